// File: rtl/lenet_roi_pkg.sv
// Shared constants and types for the LeNet ROI sampler: default ROI geometry,
// accumulator sizing and the capture FSM state encoding.
package lenet_roi_pkg;

    localparam int OUT_N_DEF    = 28;
    localparam int BLK_LOG2_DEF = 4;
    localparam int ROI_X0_DEF   = 96;
    localparam int ROI_Y0_DEF   = 16;

    localparam int ROI_SIDE = OUT_N_DEF << BLK_LOG2_DEF;
    localparam int ACC_W    = 8 + 2 * BLK_LOG2_DEF;
    localparam int OUT_PIX  = OUT_N_DEF * OUT_N_DEF;
    localparam int ADDR_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } roi_state_e;

endpackage

// File: rtl/lenet_roi_drain.sv
// Drain engine: owns the bank select, emits one completed block row as
// OUT_N valid/ready beats. LENET_ROI_INVERT_EN selects inverted (255-avg) output.
module lenet_roi_drain
    import lenet_roi_pkg::*;
#(
    parameter int OUT_N    = OUT_N_DEF,
    parameter int BLK_LOG2 = BLK_LOG2_DEF,
    parameter int AW       = 8 + 2 * BLK_LOG2,
    parameter int COL_W    = $clog2(OUT_N)
) (
    input  logic              p_clk,
    input  logic              arst_p_n,
    input  logic              trig,
    input  logic [COL_W-1:0]  row,
    input  logic [AW-1:0]     rd_acc,
    output logic [COL_W-1:0]  rd_col,
    output logic              fill_bank,
    output logic              busy,
    output logic              last_beat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_addr,
    output logic [7:0]        out_data
);

    logic             pend_q;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] row_q;
    logic [7:0]       avg;
    logic [7:0]       pix;
    logic             advance;
    logic             last_col;

    // Handshake: a beat moves when out_valid && out_ready; while stalled the
    // beat registers hold, and out_valid never drops before its transfer.
    assign last_col  = (col_q == COL_W'(OUT_N - 1));
    assign advance   = out_valid && out_ready;
    assign last_beat = advance && last_col;
    assign busy      = pend_q || out_valid;

    // Look one column ahead so the next beat's data is ready at the transfer edge.
    assign rd_col = (pend_q || last_col) ? '0 : col_q + COL_W'(1);
    assign avg    = 8'(rd_acc >> (2 * BLK_LOG2));

`ifdef LENET_ROI_INVERT_EN
    assign pix = 8'd255 - avg;
`else
    assign pix = avg;
`endif

    always_ff @(posedge p_clk or negedge arst_p_n) begin
        if (!arst_p_n) begin
            pend_q    <= 1'b0;
            fill_bank <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            pend_q <= trig;
            if (trig) begin
                fill_bank <= ~fill_bank;
                row_q     <= row;
            end
            if (pend_q) begin
                out_valid <= 1'b1;
                col_q     <= '0;
                out_addr  <= ADDR_W'(row_q) * ADDR_W'(OUT_N);
                out_data  <= pix;
            end else if (advance) begin
                if (last_col) begin
                    out_valid <= 1'b0;
                end else begin
                    col_q    <= col_q + COL_W'(1);
                    out_addr <= out_addr + ADDR_W'(1);
                    out_data <= pix;
                end
            end
        end
    end

endmodule

// File: rtl/lenet_roi_sampler.sv
// Captures one frame on request and box-averages a square ROI into an
// OUT_N x OUT_N image. Output polarity is selected by LENET_ROI_INVERT_EN.
module lenet_roi_sampler
    import lenet_roi_pkg::*;
#(
    parameter int ROI_X0   = ROI_X0_DEF,
    parameter int ROI_Y0   = ROI_Y0_DEF,
    parameter int OUT_N    = OUT_N_DEF,
    parameter int BLK_LOG2 = BLK_LOG2_DEF
) (
    input  logic       p_clk,
    input  logic       arst_p_n,
    input  logic       start,
    output logic       busy,
    input  logic       in_sof,
    input  logic       in_de,
    input  logic [9:0] in_px,
    input  logic [8:0] in_py,
    input  logic [7:0] in_pix,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_addr,
    output logic [7:0] out_data,
    output logic       frame_done,
    output logic       ovf_err
);

    localparam int SIDE  = OUT_N << BLK_LOG2;
    localparam int AW    = 8 + 2 * BLK_LOG2;
    localparam int COL_W = $clog2(OUT_N);

    roi_state_e       state_q;
    roi_state_e       state_d;
    logic [9:0]       rx;
    logic [8:0]       ry;
    logic             in_roi;
    logic             cap_active;
    logic             blk_first;
    logic             row_end;
    logic             last_brow;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] brow;
    logic [COL_W-1:0] rd_col;
    logic             fill_bank;
    logic             drain_busy;
    logic             drain_last_beat;
    logic             drain_trig;
    logic             last_row_q;
    logic [AW-1:0]    acc [2][OUT_N];
    logic [AW-1:0]    rd_acc;

    assign rx = in_px - 10'(ROI_X0);
    assign ry = in_py - 9'(ROI_Y0);

    assign in_roi = in_de
                 && ({1'b0, in_px} >= 11'(ROI_X0)) && ({1'b0, in_px} < 11'(ROI_X0 + SIDE))
                 && ({1'b0, in_py} >= 10'(ROI_Y0)) && ({1'b0, in_py} < 10'(ROI_Y0 + SIDE));

    // The in_sof pixel itself belongs to the new frame, even while still in ARM.
    assign cap_active = (state_q == CAP) || ((state_q == ARM) && in_sof);

    assign col       = rx[BLK_LOG2 +: COL_W];
    assign brow      = ry[BLK_LOG2 +: COL_W];
    assign blk_first = (rx[BLK_LOG2-1:0] == '0) && (ry[BLK_LOG2-1:0] == '0);
    assign row_end   = cap_active && in_roi && (&ry[BLK_LOG2-1:0]) && (rx == 10'(SIDE - 1));
    assign last_brow = (brow == COL_W'(OUT_N - 1));

    // A row completing while the previous one is still draining is dropped.
    assign drain_trig = row_end && !drain_busy;

    // The first pixel of each block loads its entry, so stale sums never need clearing.
    always_ff @(posedge p_clk) begin
        if (cap_active && in_roi) begin
            if (blk_first) begin
                acc[fill_bank][col] <= AW'(in_pix);
            end else begin
                acc[fill_bank][col] <= acc[fill_bank][col] + AW'(in_pix);
            end
        end
    end

    assign rd_acc = acc[~fill_bank][rd_col];

    always_ff @(posedge p_clk or negedge arst_p_n) begin
        if (!arst_p_n) begin
            state_q    <= IDLE;
            ovf_err    <= 1'b0;
            last_row_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                ovf_err    <= 1'b0;
                last_row_q <= 1'b0;
            end
            if (row_end && drain_busy) begin
                ovf_err <= 1'b1;
            end
            if ((state_q == CAP) && in_sof) begin
                ovf_err    <= 1'b1;
                last_row_q <= 1'b0;
            end else if (row_end && last_brow) begin
                last_row_q <= 1'b1;
            end
        end
    end

    // The frame ends on the transfer of the final beat once the last block
    // row has been seen, whether that row itself was drained or dropped.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (in_sof) begin
                    state_d = CAP;
                end
            end
            CAP: begin
                if (!in_sof && drain_last_beat && (last_row_q || (row_end && last_brow))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lenet_roi_drain #(
        .OUT_N    (OUT_N),
        .BLK_LOG2 (BLK_LOG2),
        .AW       (AW),
        .COL_W    (COL_W)
    ) u_drain (
        .p_clk     (p_clk),
        .arst_p_n  (arst_p_n),
        .trig      (drain_trig),
        .row       (brow),
        .rd_acc    (rd_acc),
        .rd_col    (rd_col),
        .fill_bank (fill_bank),
        .busy      (drain_busy),
        .last_beat (drain_last_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_lenet_roi_sampler.sv
// Bench for lenet_roi_sampler with a reduced 2x2 block size so several whole
// frames fit in a short run; the ROI straddles column 256 to exercise px wrap.
module tb_lenet_roi_sampler;

    localparam int X0   = 230;
    localparam int Y0   = 16;
    localparam int N    = 28;
    localparam int BL   = 1;
    localparam int B    = 1 << BL;
    localparam int SIDE = N * B;
    localparam int W    = 18;

    logic       p_clk;
    logic       arst_p_n;
    logic       start;
    logic       busy;
    logic       in_sof;
    logic       in_de;
    logic [9:0] in_px;
    logic [8:0] in_py;
    logic [7:0] in_pix;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_addr;
    logic [7:0] out_data;
    logic       frame_done;
    logic       ovf_err;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int rdy_mode = 0;
    bit lat_en   = 0;
    bit lat_pend = 0;

    logic [7:0]   img [SIDE][SIDE];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         stall_q = 0;
    logic [W-1:0] stall_beat = '0;

    lenet_roi_sampler #(
        .ROI_X0   (X0),
        .ROI_Y0   (Y0),
        .OUT_N    (N),
        .BLK_LOG2 (BL)
    ) dut (
        .p_clk      (p_clk),
        .arst_p_n   (arst_p_n),
        .start      (start),
        .busy       (busy),
        .in_sof     (in_sof),
        .in_de      (in_de),
        .in_px      (in_px),
        .in_py      (in_py),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .frame_done (frame_done),
        .ovf_err    (ovf_err)
    );

    // clock / reset
    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // monitor: collect transferred beats, check hold during stalls
    always @(negedge p_clk) begin
        if (!arst_p_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'({out_addr, out_data}), 32'(stall_beat));
            end
            if (out_valid && out_ready) got_q.push_back({out_addr, out_data});
            stall_q    = out_valid && !out_ready;
            stall_beat = {out_addr, out_data};
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    function automatic logic next_ready(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return ~out_ready;
            2:       return ($urandom_range(3) != 0);
            default: return !(rel >= 2 && rel <= 4);
        endcase
    endfunction

    function automatic bit roi(input int x, input int y);
        return (x >= X0) && (x < X0 + SIDE) && (y >= Y0) && (y < Y0 + SIDE);
    endfunction

    // reference model: image content and block averages from plain arithmetic
    task automatic fill_img(input int mode);
        for (int y = 0; y < SIDE; y++)
            for (int x = 0; x < SIDE; x++)
                case (mode)
                    0:       img[y][x] = 8'd100;
                    1:       img[y][x] = 8'((X0 + x) % 256);
                    default: img[y][x] = 8'($urandom_range(255));
                endcase
    endtask

    task automatic exp_rows(input int first, input int last, input int drop);
        for (int r = first; r <= last; r++) begin
            if (r != drop) begin
                for (int c = 0; c < N; c++) begin
                    int sum = 0;
                    int avg;
                    for (int dy = 0; dy < B; dy++)
                        for (int dx = 0; dx < B; dx++)
                            sum += int'(img[r * B + dy][c * B + dx]);
                    avg = sum / (B * B);
`ifdef LENET_ROI_INVERT_EN
                    avg = 255 - avg;
`endif
                    exp_q.push_back({10'(r * N + c), 8'(avg)});
                end
            end
        end
    endtask

    // drivers
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_sof();
        in_sof    = 1'b1;
        in_de     = 1'b1;
        in_px     = '0;
        in_py     = '0;
        in_pix    = '0;
        out_ready = next_ready(rdy_mode, -Y0);
        tick();
        in_sof = 1'b0;
    endtask

    task automatic send_lines(input int y_lo, input int y_hi, input int start_line, input int rst_line);
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int k = 0; k < SIDE + 12; k++) begin
                int x;
                bit de;
                if (k < SIDE + 8) begin
                    x  = X0 - 4 + k;
                    de = 1'b1;
                end else begin
                    x  = X0 + 5;
                    de = 1'b0;
                end
                in_sof    = 1'b0;
                in_de     = de;
                in_px     = 10'(x);
                in_py     = 9'(y);
                in_pix    = (de && roi(x, y)) ? img[y - Y0][x - X0] : 8'($urandom_range(255));
                out_ready = next_ready(rdy_mode, y - Y0);
                start     = (y == start_line) && (k == 0);
                if (y == rst_line && k == 5) begin
                    chk("drain_active_before_reset", 32'(out_valid), 32'd1);
                    arst_p_n = 1'b0;
                    #1;
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_out_addr", 32'(out_addr), 32'd0);
                    chk("rst_out_data", 32'(out_data), 32'd0);
                    chk("rst_frame_done", 32'(frame_done), 32'd0);
                    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
                    in_de = 1'b0;
                    start = 1'b0;
                    return;
                end
                tick();
                if (lat_pend) begin
                    chk("valid_two_cycles_after_row_end", 32'(out_valid), 32'd1);
                    lat_pend = 1'b0;
                end
                if (lat_en && de && y == Y0 + B - 1 && x == X0 + SIDE - 1) begin
                    chk("valid_low_one_cycle_after_row_end", 32'(out_valid), 32'd0);
                    lat_pend = 1'b1;
                end
            end
        end
        start = 1'b0;
        in_de = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        out_ready = 1'b1;
        in_de     = 1'b0;
        start     = 1'b0;
        while (fd_cnt == 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 32'(fd_cnt != 0), 32'd1);
        tick();
        tick();
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    // scoreboard compare of a finished frame
    task automatic check_frame(input string tag, input logic exp_ovf);
        chk({tag, "_beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_ovf_err"}, 32'(ovf_err), 32'(exp_ovf));
        chk({tag, "_frame_done_pulses"}, 32'(fd_cnt), 32'd1);
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic full_frame(input int pix_mode, input int rmode, input int drop, input logic exp_ovf, input string tag);
        rdy_mode = rmode;
        do_start();
        fill_img(pix_mode);
        exp_rows(0, N - 1, drop);
        send_sof();
        send_lines(Y0 - 2, Y0 + SIDE + 1, -1, -1);
        wait_done();
        check_frame(tag, exp_ovf);
    endtask

    initial begin
        arst_p_n  = 1'b0;
        start     = 1'b0;
        in_sof    = 1'b0;
        in_de     = 1'b0;
        in_px     = '0;
        in_py     = '0;
        in_pix    = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_addr", 32'(out_addr), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_ovf_err", 32'(ovf_err), 32'd0);
        tick();
        tick();
        arst_p_n = 1'b1;
        tick();

        // constant image, latency check, start while busy is ignored
        rdy_mode = 0;
        lat_en   = 1'b1;
        do_start();
        fill_img(0);
        exp_rows(0, N - 1, -1);
        send_sof();
        send_lines(Y0 - 2, Y0 + SIDE + 1, Y0 + 20, -1);
        lat_en = 1'b0;
        wait_done();
        check_frame("const", 1'b0);
        send_sof();
        send_lines(Y0 - 2, Y0 + 3, -1, -1);
        chk("no_second_capture_beats", 32'(got_q.size()), 32'd0);
        chk("no_second_capture_busy", 32'(busy), 32'd0);

        full_frame(1, 0, -1, 1'b0, "px_ramp");
        full_frame(0, 1, -1, 1'b0, "toggle_ready");
        full_frame(2, 2, -1, 1'b0, "random_ready");
        full_frame(2, 3, 1, 1'b1, "stalled_drop");

        // restart mid-ROI: rows already complete still drain, then the new frame
        rdy_mode = 0;
        do_start();
        chk("ovf_cleared_by_start", 32'(ovf_err), 32'd0);
        fill_img(2);
        exp_rows(0, 4, -1);
        send_sof();
        send_lines(Y0 - 2, Y0 + 9, -1, -1);
        fill_img(2);
        exp_rows(0, N - 1, -1);
        send_sof();
        send_lines(Y0 - 2, Y0 + SIDE + 1, -1, -1);
        wait_done();
        check_frame("restart", 1'b1);

        // asynchronous reset during the drain of row 5, then a clean frame
        rdy_mode = 0;
        do_start();
        fill_img(2);
        send_sof();
        send_lines(Y0 - 2, Y0 + SIDE + 1, -1, Y0 + 12);
        tick();
        tick();
        arst_p_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        tick();
        full_frame(2, 2, -1, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lenet_roi_sampler.md
# lenet_roi_sampler

Downstream consumer of the VGA timing controller in the pseudo-sensor path. Captures one frame on request and box-averages a square region of interest (default 448×448 at (96,16)) of the 8-bit grayscale pixel stream into a 28×28 image for the LeNet-5 input buffer. The 784 output pixels leave through a valid/ready write port as each 16-line block row completes.

## Interface
Parameters:
- ROI_X0, 96, first active column of the ROI
- ROI_Y0, 16, first active line of the ROI
- OUT_N, 28, output image side, in pixels
- BLK_LOG2, 4, log2 of block side; block = 16×16, ROI side = OUT_N<<BLK_LOG2

Ports:
- p_clk  in  1  pixel clock
- arst_p_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms capture of the next frame
- busy  out  1  high from accepted start until frame_done
- in_sof  in  1  frame-start pulse, aligned with in_de/in_px/in_py/in_pix
- in_de  in  1  active-video qualifier
- in_px  in  10  active column 0..639
- in_py  in  9  active line 0..479
- in_pix  in  8  grayscale pixel
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_addr  out  10  row*OUT_N+col, 0..783
- out_data  out  8  averaged pixel
- frame_done  out  1  one-cycle pulse after beat 783 accepted
- ovf_err  out  1  sticky; a block row was dropped

## Operation
- FSM: IDLE → (start) ARM → (in_sof) CAP → (last block row drained) DONE → IDLE (one cycle; frame_done=1).
- start is ignored outside IDLE. In ARM/CAP/DONE, busy=1.
- In CAP, a pixel is in the ROI when in_de and X0 ≤ px < X0+ROI side and Y0 ≤ py < Y0+ROI side; col=(px−X0)>>BLK_LOG2, brow=(py−Y0)>>BLK_LOG2.
- Two accumulator banks of OUT_N entries, each 8+2·BLK_LOG2 bits (16). The fill bank entry acc[col] is loaded with in_pix when (py−Y0)%16==0 and (px−X0)%16==0; otherwise in_pix is added. The sum is never saturated.
- The last ROI pixel of a block row is the cycle with (py−Y0)%16==15 and px==X0+ROI side−1. On that cycle:
  - If the drain engine is idle: the banks swap, and the drain emits cols 0..OUT_N−1 of the completed bank with out_data=acc>>(2·BLK_LOG2) and out_addr=brow*OUT_N+col.
  - If the drain engine is busy: ovf_err is set, the completed row is discarded, and the fill bank is not swapped.
- After brow OUT_N−1 is drained (or discarded), the FSM enters DONE.
- If in_sof arrives while in CAP, the capture restarts: accumulators are logically cleared via the load rule, brow tracking restarts, the drain in progress completes, and ovf_err is set.
- ovf_err clears on an accepted start.

## Timing
- Reset values: busy=0, out_valid=0, out_addr=0, out_data=0, frame_done=0, ovf_err=0; FSM=IDLE.
- Accumulator update takes effect one cycle after the pixel is sampled.
- out_valid first rises 2 cycles after the last pixel of a block row is sampled.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - out_addr and out_data hold while out_valid && !out_ready.
  - With out_ready held high, the drain produces one beat per cycle with no bubbles (28 cycles per row).
- frame_done pulses the cycle after beat 783 transfers. busy falls on the same edge.
- Asynchronous reset in any state returns all outputs to their reset values immediately. Partial results are discarded.

## Configuration
- LENET_ROI_INVERT_EN defined: out_data = 255 − average (white digit on black, MNIST polarity).
- LENET_ROI_INVERT_EN undefined: out_data = average.

## Structure
- Package lenet_roi_pkg holds:
  - defaults for OUT_N, BLK_LOG2, ROI_X0, ROI_Y0
  - derived ROI_SIDE, ACC_W, and OUT_PIX=784
  - FSM state enum {IDLE, ARM, CAP, DONE}
- One sub-module, lenet_roi_drain: holds the bank index, column counter, and valid/ready output register, and exposes busy to the parent.

## Test plan
- Constant in_pix=100, out_ready=1 → 784 beats, addr 0..783 in order, all data=100 (155 with LENET_ROI_INVERT_EN); frame_done once; ovf_err=0.
- in_pix=px[7:0] → the beat at col c has data = mean of the 16 columns X0+16c..X0+16c+15 (mod 256), identical on every row.
- out_ready toggling 1/0 every cycle → the same 784 values as the first scenario; addr and data stable during stalls.
- out_ready held 0 for 20 lines after row 0 is complete → ovf_err=1, row 1 missing, later rows emitted; frame_done still pulses.
- start while busy → ignored, no second capture. start in IDLE followed by in_sof mid-ROI (in CAP) → capture restarts, ovf_err=1.
- arst_p_n asserted during drain of row 5 → out_valid=0 and busy=0 immediately. A new start captures a full, correct frame.
